// File: rtl/add_pkg.sv
// add_pkg: FSM state encoding and default datapath widths shared by the add stages
package add_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam int ADD_IN_W  = 4;
  localparam int ADD_ACC_W = 8;
endpackage

// File: rtl/acc_sat_add.sv
// acc_sat_add: signed acc + sample with overflow detect
// ACC_SAT_EN defined clamps on overflow, otherwise the result wraps
module acc_sat_add #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  in_sum,
  output logic [ACC_W-1:0] next_acc,
  output logic             ovf
);
  logic [ACC_W:0] sum;
  assign sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){in_sum[IN_W-1]}}, in_sum};
  // exact sum is out of range when the two top bits disagree
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef ACC_SAT_EN
  assign next_acc = !ovf ? sum[ACC_W-1:0] :
                    sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign next_acc = sum[ACC_W-1:0];
`endif
endmodule

// File: rtl/add_accumulator.sv
// add_accumulator: sums COUNT signed samples per frame into a wider accumulator with sticky overflow
module add_accumulator
  import add_pkg::*;
#(
  parameter int IN_W  = ADD_IN_W,
  parameter int ACC_W = ADD_ACC_W,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf
);
  localparam int CW = $clog2(COUNT + 1);
  logic [1:0]       state;
  logic [ACC_W-1:0] acc, next_acc;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ovf, add_ovf, accept;
  acc_sat_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add (
    .acc(acc),
    .in_sum(in_sum),
    .next_acc(next_acc),
    .ovf(add_ovf)
  );
  assign in_ready  = state != ST_HOLD;
  assign out_valid = state == ST_HOLD;
  assign out_total = acc;
  assign out_ovf   = ovf;
  assign accept    = in_valid && in_ready;
  assign cnt_nxt   = cnt + 1'b1;
  // acc is zero in IDLE, so the first sample uses the same adder path
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear || (state == ST_HOLD && out_ready)) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= next_acc;
      ovf   <= ovf | add_ovf;
      cnt   <= cnt_nxt;
      state <= cnt_nxt == CW'(COUNT) ? ST_HOLD : ST_ACCUM;
    end
  end
endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: directed checks of frame sums, overflow, backpressure, clear and reset
module tb_add_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_clear = 0, a_in_valid = 0, a_out_ready = 0;
  logic [3:0] a_in_sum = '0;
  logic a_in_ready, a_out_valid, a_out_ovf;
  logic [7:0] a_out_total;
  logic b_clear = 0, b_in_valid = 0, b_out_ready = 0;
  logic [3:0] b_in_sum = '0;
  logic b_in_ready, b_out_valid, b_out_ovf;
  logic [4:0] b_out_total;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_accumulator dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sum(a_in_sum), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_total(a_out_total), .out_ovf(a_out_ovf)
  );

  add_accumulator #(.ACC_W(5), .COUNT(3)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sum(b_in_sum), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_total(b_out_total), .out_ovf(b_out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [3:0] v);
    a_in_valid = 1'b1;
    a_in_sum = v;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] v);
    b_in_valid = 1'b1;
    b_in_sum = v;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic drain_b();
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a_out_valid, a_out_total, a_out_ovf, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got v=%b t=%h o=%b r=%b want v=0 t=00 o=0 r=1",
               a_out_valid, a_out_total, a_out_ovf, a_in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frames();
    logic [3:0] vec [3][4] = '{'{4'd3, 4'd3, 4'd3, 4'd3},
                               '{4'hC, 4'hC, 4'hC, 4'hC},
                               '{4'd7, 4'h8, 4'd1, 4'd0}};
    logic [7:0] exp [3] = '{8'd12, 8'hF0, 8'h00};
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 3; i++) send_a(vec[f][i]);
      checks++;
      if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL frame%0d_early_valid got %b want 0", f, a_out_valid);
      end
      send_a(vec[f][3]);
      checks++;
      if ({a_out_valid, a_out_total, a_out_ovf, a_in_ready} !== {1'b1, exp[f], 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL frame%0d_result got v=%b t=%h o=%b r=%b want v=1 t=%h o=0 r=0",
                 f, a_out_valid, a_out_total, a_out_ovf, a_in_ready, exp[f]);
      end
      drain_a();
      checks++;
      if ({a_out_valid, a_in_ready, a_out_total} !== {1'b0, 1'b1, 8'h00}) begin
        failures++;
        $display("FAIL frame%0d_drain got v=%b r=%b t=%h want v=0 r=1 t=00",
                 f, a_out_valid, a_in_ready, a_out_total);
      end
    end
  endtask

  task automatic test_narrow();
    logic [3:0] vec [2] = '{4'd7, 4'h8};
`ifdef ACC_SAT_EN
    logic [4:0] exp [2] = '{5'h0F, 5'h10};
`else
    logic [4:0] exp [2] = '{5'h15, 5'h08};
`endif
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 3; i++) send_b(vec[f]);
      checks++;
      if ({b_out_valid, b_out_total, b_out_ovf, b_in_ready} !== {1'b1, exp[f], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL narrow%0d_result got v=%b t=%h o=%b r=%b want v=1 t=%h o=1 r=0",
                 f, b_out_valid, b_out_total, b_out_ovf, b_in_ready, exp[f]);
      end
      drain_b();
      checks++;
      if ({b_out_valid, b_out_ovf, b_out_total} !== {1'b0, 1'b0, 5'h00}) begin
        failures++;
        $display("FAIL narrow%0d_drain got v=%b o=%b t=%h want v=0 o=0 t=00",
                 f, b_out_valid, b_out_ovf, b_out_total);
      end
    end
  endtask

  task automatic test_backpressure();
    send_a(4'd1); send_a(4'd2); send_a(4'd3); send_a(4'd4);
    a_in_valid = 1'b1;
    a_in_sum = 4'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({a_out_valid, a_out_total, a_out_ovf, a_in_ready} !== {1'b1, 8'd10, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL backpressure_hold%0d got v=%b t=%h o=%b r=%b want v=1 t=0a o=0 r=0",
                 i, a_out_valid, a_out_total, a_out_ovf, a_in_ready);
      end
    end
    a_in_valid = 1'b0;
    drain_a();
    checks++;
    if ({a_out_valid, a_in_ready, a_out_total} !== {1'b0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL backpressure_release got v=%b r=%b t=%h want v=0 r=1 t=00",
               a_out_valid, a_in_ready, a_out_total);
    end
    for (int i = 0; i < 4; i++) send_a(4'd2);
    checks++;
    if ({a_out_valid, a_out_total} !== {1'b1, 8'd8}) begin
      failures++;
      $display("FAIL backpressure_next got v=%b t=%h want v=1 t=08", a_out_valid, a_out_total);
    end
    drain_a();
  endtask

  task automatic test_clear();
    send_a(4'd5); send_a(4'd5);
    a_clear = 1'b1;
    send_a(4'd5);
    a_clear = 1'b0;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_total, a_out_ovf} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL clear_state got v=%b r=%b t=%h o=%b want v=0 r=1 t=00 o=0",
               a_out_valid, a_in_ready, a_out_total, a_out_ovf);
    end
    for (int i = 0; i < 3; i++) send_a(4'd1);
    checks++;
    if ({a_out_valid, a_out_total} !== {1'b0, 8'd3}) begin
      failures++;
      $display("FAIL clear_partial got v=%b t=%h want v=0 t=03", a_out_valid, a_out_total);
    end
    send_a(4'd1);
    checks++;
    if ({a_out_valid, a_out_total} !== {1'b1, 8'd4}) begin
      failures++;
      $display("FAIL clear_next got v=%b t=%h want v=1 t=04", a_out_valid, a_out_total);
    end
    drain_a();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) send_a(4'd7);
    checks++;
    if ({a_out_valid, a_out_total} !== {1'b1, 8'd28}) begin
      failures++;
      $display("FAIL async_pre got v=%b t=%h want v=1 t=1c", a_out_valid, a_out_total);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_out_total, a_out_ovf, a_in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got v=%b t=%h o=%b r=%b want v=0 t=00 o=0 r=1",
               a_out_valid, a_out_total, a_out_ovf, a_in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_frames();
    test_narrow();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
